// File: rtl/pump_controller.sv
// Air-pump (harpoon) attack sequencer: extend, attach, inflate/pop, retract, cooldown.
// Optional feature: define PUMP_AUTOFIRE_EN to auto-repeat presses while the fire key is held.
module pump_controller #(
  parameter int MAX_LEN         = 16,
  parameter int STEP            = 2,
  parameter int INFLATE_MAX     = 3,
  parameter int DEFLATE_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 8
`ifdef PUMP_AUTOFIRE_EN
  ,
  parameter int AUTO_FRAMES     = 6
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       pump_key,
  input  logic [1:0] dir_in,
  input  logic       tip_hit,
  input  logic       tip_blocked,
  output logic       pump_active,
  output logic [4:0] pump_len,
  output logic [1:0] pump_dir,
  output logic [1:0] inflate_level,
  output logic       enemy_pop,
  output logic       player_freeze
);

  localparam int DEF_W  = $clog2(DEFLATE_FRAMES + 1);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_ATTACHED,
    S_RETRACT,
    S_COOLDOWN
  } state_e;

  state_e            state_q, state_d;
  logic              key_q;
  logic              press_q;
  logic              press;
  logic [4:0]        len_q, len_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        level_q, level_d;
  logic              pop_q, pop_d;
  logic              active_q, active_d;
  logic [DEF_W-1:0]  deflate_q, deflate_d;
  logic [COOL_W-1:0] cool_q, cool_d;

  logic [5:0] len_ext;
  logic [4:0] len_ext_sat;
  logic [4:0] len_ret;
  logic [2:0] level_inc;

  assign len_ext     = {1'b0, len_q} + 6'(STEP);
  assign len_ext_sat = (len_ext >= 6'(MAX_LEN)) ? 5'(MAX_LEN) : len_ext[4:0];
  assign len_ret     = (len_q > 5'(STEP)) ? (len_q - 5'(STEP)) : 5'd0;
  assign level_inc   = {1'b0, level_q} + 3'd1;

`ifdef PUMP_AUTOFIRE_EN
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);

  logic [AUTO_W-1:0] auto_q, auto_d;
  logic              auto_en;
  logic              auto_fire;

  // The repeat counter only runs while the key is held in a state that accepts presses.
  assign auto_en   = pump_key && (state_q == S_IDLE || state_q == S_ATTACHED);
  assign auto_fire = auto_en && frame_tick && (auto_q == AUTO_W'(AUTO_FRAMES - 1));

  always_comb begin
    auto_d = auto_q;
    if (!auto_en) begin
      auto_d = '0;
    end else if (frame_tick) begin
      auto_d = auto_fire ? '0 : auto_q + AUTO_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) auto_q <= '0;
    else          auto_q <= auto_d;
  end

  assign press = press_q | auto_fire;
`else
  assign press = press_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    dir_d     = dir_q;
    level_d   = level_q;
    pop_d     = 1'b0;
    deflate_d = deflate_q;
    cool_d    = cool_q;

    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_EXTEND;
          len_d   = 5'd0;
          dir_d   = dir_in;
          level_d = 2'd0;
        end
      end

      S_EXTEND: begin
        if (frame_tick) begin
          if (tip_hit) begin
            state_d   = S_ATTACHED;
            level_d   = 2'd1;
            deflate_d = '0;
          end else if (tip_blocked) begin
            state_d = S_RETRACT;
          end else begin
            len_d = len_ext_sat;
            if (len_ext_sat == 5'(MAX_LEN)) state_d = S_RETRACT;
          end
        end
      end

      S_ATTACHED: begin
        // A press takes precedence over a coincident tick and restarts the deflate timer.
        if (press) begin
          deflate_d = '0;
          if (level_inc >= 3'(INFLATE_MAX)) begin
            pop_d   = 1'b1;
            level_d = 2'd0;
            state_d = S_RETRACT;
          end else begin
            level_d = level_inc[1:0];
          end
        end else if (frame_tick) begin
          if (!tip_hit) begin
            level_d = 2'd0;
            state_d = S_RETRACT;
          end else if (deflate_q == DEF_W'(DEFLATE_FRAMES - 1)) begin
            deflate_d = '0;
            level_d   = level_q - 2'd1;
            if (level_q == 2'd1) state_d = S_RETRACT;
          end else begin
            deflate_d = deflate_q + DEF_W'(1);
          end
        end
      end

      S_RETRACT: begin
        if (frame_tick) begin
          len_d = len_ret;
          if (len_ret == 5'd0) begin
            state_d = S_COOLDOWN;
            cool_d  = '0;
          end
        end
      end

      S_COOLDOWN: begin
        if (frame_tick) begin
          if (cool_q == COOL_W'(COOLDOWN_FRAMES - 1)) begin
            state_d = S_IDLE;
            cool_d  = '0;
          end else begin
            cool_d = cool_q + COOL_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign active_d = (state_d == S_EXTEND) || (state_d == S_ATTACHED) || (state_d == S_RETRACT);

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      len_q     <= 5'd0;
      dir_q     <= 2'd0;
      level_q   <= 2'd0;
      pop_q     <= 1'b0;
      active_q  <= 1'b0;
      deflate_q <= '0;
      cool_q    <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= pump_key;
      press_q   <= pump_key & ~key_q;
      len_q     <= len_d;
      dir_q     <= dir_d;
      level_q   <= level_d;
      pop_q     <= pop_d;
      active_q  <= active_d;
      deflate_q <= deflate_d;
      cool_q    <= cool_d;
    end
  end

  // The player is frozen in exactly the states where the pump is drawn.
  assign pump_active   = active_q;
  assign player_freeze = active_q;
  assign pump_len      = len_q;
  assign pump_dir      = dir_q;
  assign inflate_level = level_q;
  assign enemy_pop     = pop_q;

endmodule

// File: tb/tb_pump_controller.sv
// Scoreboard bench for pump_controller: expected output vectors are queued with each
// driven cycle and compared against the DUT one clock edge later.
module tb_pump_controller;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic       pump_key;
  logic [1:0] dir_in;
  logic       tip_hit;
  logic       tip_blocked;
  logic       pump_active;
  logic [4:0] pump_len;
  logic [1:0] pump_dir;
  logic [1:0] inflate_level;
  logic       enemy_pop;
  logic       player_freeze;

  always #5 clk = ~clk;

  pump_controller dut (
    .Clk           (clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .pump_key      (pump_key),
    .dir_in        (dir_in),
    .tip_hit       (tip_hit),
    .tip_blocked   (tip_blocked),
    .pump_active   (pump_active),
    .pump_len      (pump_len),
    .pump_dir      (pump_dir),
    .inflate_level (inflate_level),
    .enemy_pop     (enemy_pop),
    .player_freeze (player_freeze)
  );

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [11:0] obs;
  assign obs = {pump_active, pump_len, pump_dir, inflate_level, enemy_pop, player_freeze};

  // Packs {active, len, dir, level, pop, freeze}; freeze is set exactly when the pump is drawn.
  function automatic logic [11:0] pv(input logic act, input int len, input logic [1:0] d,
                                     input int lvl, input logic pop);
    return {act, 5'(len), d, 2'(lvl), pop, act};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got act=%0b len=%0d dir=%0d lvl=%0d pop=%0b frz=%0b, want act=%0b len=%0d dir=%0d lvl=%0d pop=%0b frz=%0b",
               tag, got[11], got[10:6], got[5:4], got[3:2], got[1], got[0],
               exp[11], exp[10:6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs; optionally queue the outputs expected after the next edge.
  task automatic cyc(input logic t, input logic k, input logic h, input logic b,
                     input bit chk, input string tag, input logic [11:0] e);
    exp_t item;
    frame_tick  = t;
    pump_key    = k;
    tip_hit     = h;
    tip_blocked = b;
    if (chk) begin
      item.tag = tag;
      item.exp = e;
      sb_q.push_back(item);
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      check(item.tag, obs, item.exp);
    end
  endtask

  task automatic run(input logic t, input logic k, input logic h, input logic b);
    cyc(t, k, h, b, 1'b0, "", '0);
  endtask

  task automatic run_chk(input logic t, input logic k, input logic h, input logic b,
                         input string tag, input logic [11:0] e);
    cyc(t, k, h, b, 1'b1, tag, e);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    run(0, 0, 0, 0);
    Reset_n = 1'b1;
  endtask

  // Key edge registers a press; the FSM acts on it one edge later.
  task automatic fire(input logic [1:0] d, input logic hold, input string tag);
    dir_in = d;
    run(0, 1, 0, 0);
    run_chk(0, hold, 0, 0, tag, pv(1, 0, d, 0, 0));
  endtask

  initial begin
    Reset_n     = 1'b0;
    frame_tick  = 1'b0;
    pump_key    = 1'b0;
    dir_in      = 2'd0;
    tip_hit     = 1'b0;
    tip_blocked = 1'b0;
    run(0, 0, 0, 0);
    run_chk(1, 0, 0, 0, "reset_state", pv(0, 0, 0, 0, 0));
    Reset_n = 1'b1;

    // Reset in the middle of an extension.
    fire(2'd2, 1'b0, "t1_fire");
    for (int k = 1; k <= 3; k++) run_chk(1, 0, 0, 0, "t1_extend", pv(1, 2 * k, 2'd2, 0, 0));
    run_chk(0, 0, 0, 0, "t1_no_tick_hold", pv(1, 6, 2'd2, 0, 0));
    Reset_n = 1'b0;
    run_chk(1, 0, 0, 0, "t1_reset_mid_extend", pv(0, 0, 0, 0, 0));
    Reset_n = 1'b1;
    run_chk(1, 0, 0, 0, "t1_idle_after_reset", pv(0, 0, 0, 0, 0));

    // Full-length shot, retract, cooldown boundary.
    fire(2'd2, 1'b0, "t2_fire");
    for (int k = 1; k <= 8; k++) run_chk(1, 0, 0, 0, "t2_extend", pv(1, 2 * k, 2'd2, 0, 0));
    for (int k = 1; k <= 8; k++) run_chk(1, 0, 0, 0, "t2_retract", pv(k < 8, 16 - 2 * k, 2'd2, 0, 0));
    for (int k = 1; k <= 7; k++) run(1, 0, 0, 0);
    run(0, 1, 0, 0);
    run_chk(0, 0, 0, 0, "t2_cooldown_press_ignored", pv(0, 0, 2'd2, 0, 0));
    run_chk(1, 0, 0, 0, "t2_cooldown_end", pv(0, 0, 2'd2, 0, 0));
    fire(2'd1, 1'b0, "t2_fire_after_cooldown");

    // Attach at length 6, inflate twice, pop, retract.
    do_reset();
    fire(2'd0, 1'b0, "t3_fire");
    for (int k = 1; k <= 3; k++) run_chk(1, 0, 0, 0, "t3_extend", pv(1, 2 * k, 2'd0, 0, 0));
    run_chk(1, 0, 1, 0, "t3_attach", pv(1, 6, 2'd0, 1, 0));
    run(0, 1, 1, 0);
    run_chk(0, 0, 1, 0, "t3_inflate2", pv(1, 6, 2'd0, 2, 0));
    run(0, 1, 1, 0);
    run_chk(0, 0, 1, 0, "t3_pop", pv(1, 6, 2'd0, 0, 1));
    run_chk(0, 0, 1, 0, "t3_pop_single", pv(1, 6, 2'd0, 0, 0));
    for (int k = 1; k <= 3; k++) run_chk(1, 0, 1, 0, "t3_retract", pv(k < 3, 6 - 2 * k, 2'd0, 0, 0));

    // Deflation with no presses: enemy escapes after 60 idle ticks.
    do_reset();
    fire(2'd3, 1'b0, "t4_fire");
    run_chk(1, 0, 0, 0, "t4_extend", pv(1, 2, 2'd3, 0, 0));
    run_chk(1, 0, 1, 0, "t4_attach", pv(1, 2, 2'd3, 1, 0));
    run(0, 1, 1, 0);
    run_chk(0, 0, 1, 0, "t4_level2", pv(1, 2, 2'd3, 2, 0));
    for (int k = 1; k <= 60; k++) begin
      if (k == 29 || k == 30 || k == 59 || k == 60)
        run_chk(1, 0, 1, 0, "t4_deflate", pv(1, 2, 2'd3, (k < 30) ? 2 : ((k < 60) ? 1 : 0), 0));
      else
        run(1, 0, 1, 0);
    end
    run_chk(1, 0, 1, 0, "t4_retracted", pv(0, 0, 2'd3, 0, 0));

    // Hit and block together attaches; losing the hit retracts; block alone retracts.
    do_reset();
    fire(2'd2, 1'b0, "t5_fire");
    run_chk(1, 0, 0, 0, "t5_extend", pv(1, 2, 2'd2, 0, 0));
    run_chk(1, 0, 1, 1, "t5_hit_and_block", pv(1, 2, 2'd2, 1, 0));
    run_chk(1, 0, 0, 0, "t5_hit_lost", pv(1, 2, 2'd2, 0, 0));
    run_chk(1, 0, 0, 0, "t5_retract_done", pv(0, 0, 2'd2, 0, 0));
    do_reset();
    fire(2'd2, 1'b0, "t5b_fire");
    for (int k = 1; k <= 2; k++) run_chk(1, 0, 0, 0, "t5b_extend", pv(1, 2 * k, 2'd2, 0, 0));
    run_chk(1, 0, 0, 1, "t5b_blocked", pv(1, 4, 2'd2, 0, 0));
    run_chk(1, 0, 0, 0, "t5b_retract_from_4", pv(1, 2, 2'd2, 0, 0));

    // Holding the key while attached.
    do_reset();
    fire(2'd1, 1'b1, "t6_fire");
    run_chk(1, 1, 1, 0, "t6_attach", pv(1, 0, 2'd1, 1, 0));
    for (int k = 1; k <= 12; k++) begin
`ifdef PUMP_AUTOFIRE_EN
      run_chk(1, 1, 1, 0, "t6_autofire",
              pv(1, 0, 2'd1, (k < 6) ? 1 : ((k < 12) ? 2 : 0), k == 12));
`else
      run_chk(1, 1, 1, 0, "t6_hold_no_inflate", pv(1, 0, 2'd1, 1, 0));
`endif
    end
    run_chk(0, 0, 1, 0, "t6_after_hold",
`ifdef PUMP_AUTOFIRE_EN
            pv(1, 0, 2'd1, 0, 0));
`else
            pv(1, 0, 2'd1, 1, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
